// File: rtl/calc_sequencer.sv
// calc_sequencer -- phase sequencer for the DE-10 Lite scientific calculator.
//
// Debounces the ENTER/CLEAR keys, walks IDLE -> IN1 -> MODE -> IN2 -> CALC -> OUT,
// latches operands/mode/opcode from the switches and runs a start/done
// handshake with the ALU, with a cycle-count timeout.
//
// Ports
//   clk, rst_n               system clock, async active-low reset
//   btn_enter_n, btn_clear_n raw active-low keys (asynchronous to clk)
//   sw_data, sw_mode, sw_op  operand / mode / opcode switches
//   alu_done, alu_result     ALU completion strobe and result
//   state                    phase code for the prompt decoder
//   calcmod                  mode (live in MODE, latched elsewhere)
//   operand_a, operand_b     latched operands
//   opcode                   latched opcode
//   alu_start                one-cycle start pulse on CALC entry
//   result, err              latched result and timeout flag
//   busy                     high while in CALC

// Per-key conditioning: 2-flop synchronizer, stable-level counter, and a
// one-cycle pulse on the debounced press (high -> low) edge.
module calc_debounce #(
  parameter int CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);
  localparam int CW = (CYCLES < 2) ? 1 : $clog2(CYCLES + 1);

  logic [1:0]    sync;
  logic          level;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= 2'b11;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], key_n};
      press <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(CYCLES - 1)) begin
        // CYCLES-th consecutive differing sample: accept the new level.
        level <= sync[1];
        cnt   <= '0;
        press <= level;  // old level high means this is a press
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module calc_sequencer #(
  parameter int DW              = 8,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          btn_enter_n,
  input  logic          btn_clear_n,
  input  logic [DW-1:0] sw_data,
  input  logic          sw_mode,
  input  logic [3:0]    sw_op,
  input  logic          alu_done,
  input  logic [DW-1:0] alu_result,
  output logic [2:0]    state,
  output logic          calcmod,
  output logic [DW-1:0] operand_a,
  output logic [DW-1:0] operand_b,
  output logic [3:0]    opcode,
  output logic          alu_start,
  output logic [DW-1:0] result,
  output logic          err,
  output logic          busy
);
  localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'b000,
    S_IN1  = 3'b001,
    S_MODE = 3'b010,
    S_IN2  = 3'b011,
    S_OUT  = 3'b100,
    S_CALC = 3'b111
  } st_t;

  st_t cur, nxt;

  // key index 0 = enter, 1 = clear
  logic [1:0] keys_n, press;
  assign keys_n = {btn_clear_n, btn_enter_n};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      calc_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (keys_n[gi]),
        .press (press[gi])
      );
    end
  endgenerate

  logic enter_p, clear_p;
  assign enter_p = press[0];
  assign clear_p = press[1];

  logic [TW-1:0] tcnt;
  logic          mode_q;
  logic [3:0]    op_q;
  logic          in_calc, first_calc, done_ok, tmo;

  // tcnt is cleared on CALC entry, so zero marks the first CALC cycle.
  assign in_calc    = (cur == S_CALC);
  assign first_calc = in_calc && (tcnt == '0);
  assign done_ok    = in_calc && alu_done && !first_calc;
  assign tmo        = in_calc && (tcnt == TW'(TIMEOUT_CYCLES));

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur <= S_IDLE;
    else        cur <= nxt;
  end

  // next state
  always_comb begin
    nxt = cur;
    if (clear_p) begin
      nxt = S_IDLE;
    end else begin
      case (cur)
        S_IDLE:  if (enter_p) nxt = S_IN1;
        S_IN1:   if (enter_p) nxt = S_MODE;
        S_MODE:  if (enter_p) nxt = S_IN2;
        S_IN2:   if (enter_p) nxt = S_CALC;
        S_CALC:  if (done_ok || tmo) nxt = S_OUT;  // done wins below
        S_OUT:   if (enter_p) nxt = S_IDLE;
        default: nxt = S_IDLE;
      endcase
    end
  end

  // datapath latches and timeout counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      operand_a <= '0;
      operand_b <= '0;
      op_q      <= '0;
      mode_q    <= 1'b0;
      result    <= '0;
      err       <= 1'b0;
      tcnt      <= '0;
    end else if (clear_p) begin
      operand_a <= '0;
      operand_b <= '0;
      op_q      <= '0;
      mode_q    <= 1'b0;
      result    <= '0;
      err       <= 1'b0;
      tcnt      <= '0;
    end else begin
      if (cur == S_IN1 && enter_p) operand_a <= sw_data;
      if (cur == S_MODE && enter_p) begin
        mode_q <= sw_mode;
        op_q   <= sw_op;
      end
      if (cur == S_IN2 && enter_p) begin
        operand_b <= sw_data;
        tcnt      <= '0;
      end
      if (in_calc) begin
        if (done_ok) begin
          result <= alu_result;
          err    <= 1'b0;
        end else if (tmo) begin
          result <= '0;
          err    <= 1'b1;
        end
        if (!tmo) tcnt <= tcnt + 1'b1;
      end
    end
  end

  // outputs; alu_start is decoded from state so async reset drops it at once
  always_comb begin
    state     = cur;
    busy      = in_calc;
    alu_start = first_calc;
    opcode    = op_q;
    calcmod   = (cur == S_MODE) ? sw_mode : mode_q;
  end
endmodule

// File: tb/tb_calc_sequencer.sv
module tb_calc_sequencer;
  localparam int D  = 4;
  localparam int T  = 8;
  localparam int DW = 8;

  logic          clk, rst_n, btn_enter_n, btn_clear_n;
  logic [DW-1:0] sw_data, alu_result;
  logic          sw_mode, alu_done;
  logic [3:0]    sw_op;
  logic [2:0]    state;
  logic          calcmod, alu_start, err, busy;
  logic [DW-1:0] operand_a, operand_b, result;
  logic [3:0]    opcode;

  calc_sequencer #(.DW(DW), .DEBOUNCE_CYCLES(D), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .btn_enter_n(btn_enter_n), .btn_clear_n(btn_clear_n),
    .sw_data(sw_data), .sw_mode(sw_mode), .sw_op(sw_op), .alu_done(alu_done),
    .alu_result(alu_result), .state(state), .calcmod(calcmod), .operand_a(operand_a),
    .operand_b(operand_b), .opcode(opcode), .alu_start(alu_start), .result(result),
    .err(err), .busy(busy)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  int errs = 0, checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // observers (read-only)
  int         start_cnt = 0;
  bit         rec = 0;
  logic [2:0] seq[$];
  initial forever begin
    @(negedge clk);
    if (alu_start) start_cnt++;
    if (rec && (seq.size() == 0 || seq[$] != state)) seq.push_back(state);
  end

  // reference model: phase number plus the values the user has committed
  int         m_st;
  logic [7:0] m_a, m_b, m_res;
  logic [3:0] m_op;
  logic       m_mod, m_err;

  function automatic void m_clear();
    m_st = 0; m_a = 0; m_b = 0; m_res = 0; m_op = 0; m_mod = 0; m_err = 0;
  endfunction

  function automatic void m_enter();
    case (m_st)
      0: m_st = 1;
      1: begin m_a = sw_data; m_st = 2; end
      2: begin m_mod = sw_mode; m_op = sw_op; m_st = 3; end
      3: begin m_b = sw_data; m_st = 7; end
      4: m_st = 0;
      default: ;
    endcase
  endfunction

  function automatic void m_finish(input bit ok, input logic [7:0] v);
    m_res = ok ? v : 8'h00;
    m_err = !ok;
    m_st  = 4;
  endfunction

  task automatic cmp_all(input string tag);
    chk({tag, ".state"}, 32'(state), 32'(m_st));
    chk({tag, ".a"},     32'(operand_a), 32'(m_a));
    chk({tag, ".b"},     32'(operand_b), 32'(m_b));
    chk({tag, ".op"},    32'(opcode), 32'(m_op));
    chk({tag, ".mod"},   32'(calcmod), 32'((m_st == 2) ? sw_mode : m_mod));
    chk({tag, ".res"},   32'(result), 32'(m_res));
    chk({tag, ".err"},   32'(err), 32'(m_err));
    chk({tag, ".busy"},  32'(busy), 32'(m_st == 7));
  endtask

  // Press and hold: the state moves on the (D+3)-th edge. Keys stay low.
  task automatic press(input bit ent, input bit clr, input string tag);
    @(negedge clk);
    if (ent) btn_enter_n = 0;
    if (clr) btn_clear_n = 0;
    repeat (D + 3) @(posedge clk);
    #1;
    if (clr) m_clear(); else m_enter();
    cmp_all(tag);
  endtask

  task automatic release_keys();
    @(negedge clk);
    btn_enter_n = 1; btn_clear_n = 1;
    repeat (D + 4) @(negedge clk);
  endtask

  task automatic to_in2(input string tag);
    press(1, 0, {tag, ".i1"}); release_keys();
    sw_data = 8'($urandom);
    press(1, 0, {tag, ".md"}); release_keys();
    sw_mode = 1'($urandom); sw_op = 4'($urandom); sw_data = 8'($urandom);
    press(1, 0, {tag, ".i2"}); release_keys();
    sw_data = 8'($urandom);
  endtask

  task automatic to_calc(input string tag);
    to_in2(tag);
    press(1, 0, {tag, ".calc"});
  endtask

  // Called just after the CALC-entry edge; counts edges until OUT.
  task automatic run_calc(input bit use_alu, input int dly, input logic [7:0] val,
                          input int exp_n, input string tag);
    int n = 0;
    chk({tag, ".start0"}, 32'(alu_start), 32'd1);
    while (n < 40) begin
      @(negedge clk);
      btn_enter_n = 1; btn_clear_n = 1;
      if (use_alu && n == dly - 1) begin alu_done = 1; alu_result = val; end
      else alu_done = 0;
      @(posedge clk); #1;
      n++;
      if (n == 1) chk({tag, ".start1"}, 32'(alu_start), 32'd0);
      if (state == 3'b100) break;
    end
    @(negedge clk) alu_done = 0;
    chk({tag, ".lat"}, 32'(n), 32'(exp_n));
    m_finish(use_alu, val);
    cmp_all(tag);
    repeat (D + 4) @(negedge clk);
  endtask

  initial begin
    int s0, len, dly;
    logic [7:0] v;
    logic [2:0] exp_seq [6];
    exp_seq = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b111, 3'b100};
    rst_n = 0; btn_enter_n = 1; btn_clear_n = 1;
    sw_data = 0; sw_mode = 0; sw_op = 0; alu_done = 0; alu_result = 0;
    m_clear();
    #3;
    cmp_all("rst");
    chk("rst.start", 32'(alu_start), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1;

    // idle with keys released
    repeat (50) @(negedge clk);
    cmp_all("idle");
    chk("idle.starts", 32'(start_cnt), 32'd0);

    // bounce: short low bursts give nothing, a long hold gives one step
    for (int k = 0; k < int'($urandom_range(2, 4)); k++) begin
      len = $urandom_range(1, 3);
      @(negedge clk) btn_enter_n = 0;
      repeat (len) @(negedge clk);
      btn_enter_n = 1;
      repeat (3) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    cmp_all("bounce.none");
    btn_enter_n = 0;
    repeat (D + 2) @(posedge clk);
    #1 chk("bounce.early", 32'(state), 32'd0);
    @(posedge clk); #1;
    m_enter();
    cmp_all("bounce.lat");
    repeat (40 - (D + 3)) @(posedge clk);
    #1 cmp_all("bounce.hold");
    release_keys();
    press(0, 1, "clr_in1"); release_keys();

    // directed full pass
    s0 = start_cnt;
    rec = 1;
    press(1, 0, "p1"); release_keys();
    sw_data = 8'h12;
    press(1, 0, "p2"); release_keys();
    sw_data = 8'h77; sw_mode = 0; sw_op = 4'h3;
    #1 chk("mode.live0", 32'(calcmod), 32'd0);
    sw_mode = 1;
    #1 chk("mode.live1", 32'(calcmod), 32'd1);
    press(1, 0, "p3"); release_keys();
    sw_data = 8'h34;
    press(1, 0, "p4");
    run_calc(1, 3, 8'h46, 3, "pass");
    rec = 0;
    chk("pass.a", 32'(operand_a), 32'h12);
    chk("pass.b", 32'(operand_b), 32'h34);
    chk("pass.op", 32'(opcode), 32'h3);
    chk("pass.mod", 32'(calcmod), 32'd1);
    chk("pass.res", 32'(result), 32'h46);
    chk("pass.starts", 32'(start_cnt - s0), 32'd1);
    chk("pass.seqlen", 32'(seq.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      if (i < seq.size()) chk($sformatf("pass.seq%0d", i), 32'(seq[i]), 32'(exp_seq[i]));
    press(1, 0, "out2idle"); release_keys();

    // timeout, then a late done in OUT
    to_calc("to");
    run_calc(0, 0, 8'h00, T + 1, "tmo");
    chk("tmo.err", 32'(err), 32'd1);
    chk("tmo.res", 32'(result), 32'd0);
    @(negedge clk) alu_done = 1; alu_result = 8'($urandom_range(1, 255));
    repeat (2) @(negedge clk);
    alu_done = 0;
    cmp_all("late");
    press(1, 0, "tmo.idle"); release_keys();

    // randomized passes
    for (int k = 0; k < 3; k++) begin
      to_calc($sformatf("r%0d", k));
      dly = $urandom_range(2, 6);
      v = 8'($urandom_range(1, 255));
      run_calc(1, dly, v, dly, $sformatf("r%0d.calc", k));
      press(1, 0, $sformatf("r%0d.idle", k)); release_keys();
    end

    // clear lands in CALC on the same edge as alu_done
    to_in2("cc");
    @(negedge clk) btn_enter_n = 0;
    repeat (2) @(negedge clk);
    btn_clear_n = 0;
    repeat (4) @(posedge clk);
    @(posedge clk); #1;
    m_enter();
    cmp_all("cc.enter");
    chk("cc.start", 32'(alu_start), 32'd1);
    @(negedge clk) btn_enter_n = 1;
    @(posedge clk); #1 cmp_all("cc.hold");
    @(negedge clk) alu_done = 1; alu_result = 8'h5A;
    @(posedge clk); #1;
    m_clear();
    cmp_all("cc.clear");
    chk("cc.res", 32'(result), 32'd0);
    @(negedge clk) alu_done = 0;
    release_keys();

    // clear and enter together in IN2
    to_in2("co");
    press(1, 1, "co.both"); release_keys();

    // async reset while alu_start is high
    to_calc("rs");
    chk("rs.start", 32'(alu_start), 32'd1);
    #2 rst_n = 0;
    #1;
    m_clear();
    cmp_all("rs.async");
    chk("rs.start0", 32'(alu_start), 32'd0);
    @(negedge clk) btn_enter_n = 1; btn_clear_n = 1;
    repeat (D + 4) @(negedge clk);
    rst_n = 1;
    repeat (D + 6) @(negedge clk);
    cmp_all("rs.after");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
